microsequencer: RTL and testbench
=================================

// Module: microsequencer
// PURPOSE
//  Next-state engine for the microprogrammed control unit. Consumes the next-state
//  fields of the current control word (n_sel, inv, cond_sel, cr) plus status
//  conditions, and registers the 7-bit current_state that addresses the control-word
//  store. Closes the control loop: state -> control word -> next state.
// PARAMETERS
//  STATE_W     7    width of state code / CR field
//  LAST_STATE  60   highest legal state; larger next-state values are illegal
//  FETCH_STATE 0    state entered on reset, illegal next-state or wait timeout
//  WAIT_MAX    15   max consecutive stall cycles in WAIT before timeout (1..255)
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        synchronous, active-high
//  n_sel         in   3        next-state select from control word
//  inv           in   1        invert selected condition
//  cond_sel      in   2        0=moc 1=alu_zero 2=alu_neg 3=constant 1
//  cr            in   STATE_W  control-register jump target from control word
//  enc_state     in   STATE_W  entry state from instruction encoder
//  moc           in   1        memory operation complete
//  alu_zero      in   1        ALU zero flag
//  alu_neg       in   1        ALU negative flag
//  current_state out  STATE_W  registered state, drives control-word store address
//  stall         out  1        comb: high while a WAIT holds the state
//  timeout       out  1        sticky: WAIT exceeded WAIT_MAX
//  illegal       out  1        sticky: illegal n_sel or next state > LAST_STATE
// BEHAVIOUR
//  - Reset (sync): current_state=FETCH_STATE, wait_cnt=0, timeout=0, illegal=0,
//    ret_reg=0, ret_valid=0. Reset wins over every other event, including mid-WAIT.
//  - c = cond_in[cond_sel] ^ inv. inc = current_state+1, computed STATE_W+1 wide.
//  - n_sel decode, next state loaded on every clk edge:
//    000 ENC   -> enc_state
//    001 FETCH -> FETCH_STATE
//    010 JUMP  -> cr
//    011 INC   -> inc
//    100 BR    -> c ? cr : inc
//    101 WAIT  -> c ? inc : current_state (stall=~c)
//    110 CALL  -> see CONFIGURATION
//    111 RET   -> see CONFIGURATION
//  - Latency: one cycle from fields to current_state; stall is combinational.
//  - WAIT: wait_cnt increments each stalled cycle, clears on any non-stalled cycle.
//    If stalled with wait_cnt==WAIT_MAX-1: next=FETCH_STATE, timeout<=1, wait_cnt<=0.
//    Condition true on same cycle as the limit: advance wins, no timeout.
//  - Range check on the selected next value: if > LAST_STATE (includes inc wrap
//    127->0 carry), load FETCH_STATE and set illegal. Fetch redirect never itself
//    illegal.
//  - Sticky flags clear only on reset.
// CONFIGURATION
//  MICROSEQ_RETURN_EN defined: one-level microsubroutine.
//    CALL: ret_reg<=inc, ret_valid<=1, next=cr. Nested CALL overwrites ret_reg.
//    RET: ret_valid ? next=ret_reg and ret_valid<=0 : next=FETCH_STATE, illegal<=1.
//    Range check applies to CALL and RET targets.
//  Not defined: no ret_reg; 110/111 -> next=FETCH_STATE, illegal<=1.
// TESTING
//  1 reset high two cycles mid-WAIT -> current_state=0, stall/timeout/illegal=0
//  2 state 5, n_sel=011 -> 6; n_sel=010 cr=44 -> 44; n_sel=000 enc_state=12 -> 12
//  3 BR cond_sel=1 alu_zero=1 inv=0 cr=20 -> 20; same with inv=1 from state 20 -> 21
//  4 WAIT cond_sel=0, moc low 3 cycles then high -> stall 3 cycles, state held, then
//    state+1, timeout=0
//  5 WAIT moc low 15 cycles -> state=0 on 15th edge, timeout=1 until reset
//  6 state 60 INC -> 0, illegal=1; macro on: CALL cr=30 from 9 -> 30, RET -> 10;
//    RET again -> 0 with illegal=1; macro off: CALL -> 0, illegal=1

Source files
------------

// File: rtl/microsequencer_if.sv
// Control-word next-state fields, status conditions and sequencer outputs.
// The control store / datapath side is the master, the sequencer is the slave.
interface microsequencer_if #(
    parameter int STATE_W = 7
);
    logic [2:0]         n_sel;
    logic               inv;
    logic [1:0]         cond_sel;
    logic [STATE_W-1:0] cr;
    logic [STATE_W-1:0] enc_state;
    logic               moc;
    logic               alu_zero;
    logic               alu_neg;
    logic [STATE_W-1:0] current_state;
    logic               stall;
    logic               timeout;
    logic               illegal;

    modport master (
        output n_sel, inv, cond_sel, cr, enc_state, moc, alu_zero, alu_neg,
        input  current_state, stall, timeout, illegal
    );

    modport slave (
        input  n_sel, inv, cond_sel, cr, enc_state, moc, alu_zero, alu_neg,
        output current_state, stall, timeout, illegal
    );
endinterface

// File: rtl/microsequencer.sv
// Next-state engine of the microprogrammed control unit: registers current_state.
// Define MICROSEQ_RETURN_EN to enable the one-level CALL/RET microsubroutine.
module microsequencer #(
    parameter int STATE_W     = 7,
    parameter int LAST_STATE  = 60,
    parameter int FETCH_STATE = 0,
    parameter int WAIT_MAX    = 15
) (
    input  logic            clk,
    input  logic            reset,
    microsequencer_if.slave bus
);
    localparam int                 CW         = STATE_W + 1;
    localparam logic [CW-1:0]      LAST_EXT   = CW'(LAST_STATE);
    localparam logic [STATE_W-1:0] FETCH_CODE = STATE_W'(FETCH_STATE);
    localparam logic [7:0]         WAIT_LIMIT = 8'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        OP_ENC   = 3'b000,
        OP_FETCH = 3'b001,
        OP_JUMP  = 3'b010,
        OP_INC   = 3'b011,
        OP_BR    = 3'b100,
        OP_WAIT  = 3'b101,
        OP_CALL  = 3'b110,
        OP_RET   = 3'b111
    } op_e;

    op_e                op;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [7:0]         wait_cnt_q;
    logic [7:0]         wait_cnt_d;
    logic               timeout_q;
    logic               illegal_q;
    logic [CW-1:0]      inc;
    logic [CW-1:0]      cand;
    logic [3:0]         cond_in;
    logic               c;
    logic               redirect;
    logic               bad_op;
    logic               range_bad;
    logic               stall_c;
    logic               timeout_hit;
`ifdef MICROSEQ_RETURN_EN
    logic [STATE_W-1:0] ret_reg;
    logic               ret_valid;
    logic               ret_load;
    logic               ret_clear;
`endif

    assign op      = op_e'(bus.n_sel);
    assign cond_in = {1'b1, bus.alu_neg, bus.alu_zero, bus.moc};
    assign c       = cond_in[bus.cond_sel] ^ bus.inv;
    // One bit wider so 127+1 carries out and fails the range check.
    assign inc     = {1'b0, state_q} + CW'(1);

    always_comb begin
        cand        = {1'b0, state_q};
        redirect    = 1'b0;
        bad_op      = 1'b0;
        stall_c     = 1'b0;
        timeout_hit = 1'b0;
        wait_cnt_d  = 8'd0;
`ifdef MICROSEQ_RETURN_EN
        ret_load    = 1'b0;
        ret_clear   = 1'b0;
`endif
        case (op)
            OP_ENC:   cand = {1'b0, bus.enc_state};
            OP_FETCH: redirect = 1'b1;
            OP_JUMP:  cand = {1'b0, bus.cr};
            OP_INC:   cand = inc;
            OP_BR:    cand = c ? {1'b0, bus.cr} : inc;
            OP_WAIT: begin
                if (c) begin
                    cand = inc;
                end else begin
                    stall_c = 1'b1;
                    // Condition wins over the limit; only a stalled cycle can time out.
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        redirect    = 1'b1;
                        timeout_hit = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
`ifdef MICROSEQ_RETURN_EN
            OP_CALL: begin
                ret_load = 1'b1;
                cand     = {1'b0, bus.cr};
            end
            OP_RET: begin
                ret_clear = 1'b1;
                if (ret_valid) begin
                    cand = {1'b0, ret_reg};
                end else begin
                    redirect = 1'b1;
                    bad_op   = 1'b1;
                end
            end
`else
            OP_CALL, OP_RET: begin
                redirect = 1'b1;
                bad_op   = 1'b1;
            end
`endif
            default: redirect = 1'b1;
        endcase

        // The fetch redirect itself is never range-checked.
        range_bad = !redirect && (cand > LAST_EXT);
        state_d   = (redirect || range_bad) ? FETCH_CODE : cand[STATE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH_CODE;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_hit) timeout_q <= 1'b1;
            if (bad_op || range_bad) illegal_q <= 1'b1;
        end
    end

`ifdef MICROSEQ_RETURN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_reg   <= '0;
            ret_valid <= 1'b0;
        end else if (ret_load) begin
            ret_reg   <= inc[STATE_W-1:0];
            ret_valid <= 1'b1;
        end else if (ret_clear) begin
            ret_valid <= 1'b0;
        end
    end
`endif

    assign bus.current_state = state_q;
    assign bus.stall         = stall_c;
    assign bus.timeout       = timeout_q;
    assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: expected states are queued as each
// control word is driven and popped after the following clock edge.
module tb_microsequencer;
    localparam int STATE_W = 7;
    localparam logic [2:0] NS_ENC = 3'b000, NS_FETCH = 3'b001, NS_JUMP = 3'b010,
                           NS_INC = 3'b011, NS_BR = 3'b100, NS_WAIT = 3'b101,
                           NS_CALL = 3'b110, NS_RET = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [STATE_W-1:0] exp_q[$];
    logic [STATE_W-1:0] exp_s;

    always #5 clk = ~clk;

    microsequencer_if #(.STATE_W(STATE_W)) bus ();

    microsequencer #(
        .STATE_W(STATE_W), .LAST_STATE(60), .FETCH_STATE(0), .WAIT_MAX(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ns, input logic iv, input logic [1:0] cs,
                         input logic [6:0] c_r, input logic [6:0] enc);
        bus.n_sel     = ns;
        bus.inv       = iv;
        bus.cond_sel  = cs;
        bus.cr        = c_r;
        bus.enc_state = enc;
    endtask

    task automatic flags(input logic m, input logic z, input logic n);
        bus.moc      = m;
        bus.alu_zero = z;
        bus.alu_neg  = n;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(NS_FETCH, 1'b0, 2'd0, 7'd0, 7'd0);
        cycle();
        cycle();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Puts the sequencer in a known state with a JUMP (not checked).
    task automatic go_to(input logic [6:0] s);
        drive(NS_JUMP, 1'b0, 2'd0, s, 7'd0);
        cycle();
    endtask

    task automatic test_reset();
        flags(1'b0, 1'b0, 1'b0);
        do_reset();
        checks++;
        if (bus.current_state !== 7'd0 || bus.timeout !== 1'b0 || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: state=%0d timeout=%b illegal=%b, want 0/0/0",
                     bus.current_state, bus.timeout, bus.illegal);
        end
        go_to(7'd3);
        drive(NS_WAIT, 1'b0, 2'd0, 7'd0, 7'd0);
        cycle();
        cycle();
        checks++;
        if (bus.stall !== 1'b1 || bus.current_state !== 7'd3) begin
            failures++;
            $display("FAIL reset_prewait: stall=%b state=%0d, want 1/3", bus.stall, bus.current_state);
        end
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        drive(NS_FETCH, 1'b0, 2'd0, 7'd0, 7'd0);
        #1;
        checks++;
        if (bus.current_state !== 7'd0 || bus.stall !== 1'b0 || bus.timeout !== 1'b0 ||
            bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_midwait: state=%0d stall=%b timeout=%b illegal=%b, want 0/0/0/0",
                     bus.current_state, bus.stall, bus.timeout, bus.illegal);
        end
        // A fresh wait counter allows 14 full stalls without timing out.
        go_to(7'd3);
        drive(NS_WAIT, 1'b0, 2'd0, 7'd0, 7'd0);
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(7'd3);
            cycle();
            exp_s = exp_q.pop_front();
            checks++;
            if (bus.current_state !== exp_s) begin
                failures++;
                $display("FAIL reset_waitcnt[%0d]: state=%0d want %0d", i, bus.current_state, exp_s);
            end
        end
        flags(1'b1, 1'b0, 1'b0);
        exp_q.push_back(7'd4);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_waitcnt_end: state=%0d timeout=%b want %0d/0",
                     bus.current_state, bus.timeout, exp_s);
        end
    endtask

    task automatic test_sequence();
        logic [2:0] ns_t[6];
        logic [6:0] cr_t[6];
        logic [6:0] enc_t[6];
        logic [6:0] ex_t[6];
        ns_t  = '{NS_JUMP, NS_INC, NS_JUMP, NS_ENC, NS_INC, NS_FETCH};
        cr_t  = '{7'd5, 7'd0, 7'd44, 7'd0, 7'd0, 7'd9};
        enc_t = '{7'd0, 7'd0, 7'd0, 7'd12, 7'd0, 7'd33};
        ex_t  = '{7'd5, 7'd6, 7'd44, 7'd12, 7'd13, 7'd0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(ns_t[i], 1'b0, 2'd0, cr_t[i], enc_t[i]);
            exp_q.push_back(ex_t[i]);
            cycle();
            exp_s = exp_q.pop_front();
            checks++;
            if (bus.current_state !== exp_s) begin
                failures++;
                $display("FAIL seq[%0d]: state=%0d want %0d", i, bus.current_state, exp_s);
            end
        end
    endtask

    task automatic test_branch();
        logic [6:0] s, tgt;
        logic [1:0] cs;
        logic iv, m, z, n, cv;
        do_reset();
        go_to(7'd7);
        flags(1'b0, 1'b1, 1'b0);
        drive(NS_BR, 1'b0, 2'd1, 7'd20, 7'd0);
        exp_q.push_back(7'd20);
        cycle();
        drive(NS_BR, 1'b1, 2'd1, 7'd20, 7'd0);
        exp_q.push_back(7'd21);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== 7'd21 || exp_s !== 7'd20) begin
            failures++;
            $display("FAIL br_fixed: state=%0d want 21 (first target queued %0d)", bus.current_state, exp_s);
        end
        exp_s = exp_q.pop_front();
        // Random branches over all condition sources.
        for (int i = 0; i < 24; i++) begin
            s   = 7'($urandom_range(0, 59));
            tgt = 7'($urandom_range(0, 60));
            cs  = 2'($urandom_range(0, 3));
            iv  = 1'($urandom_range(0, 1));
            m   = 1'($urandom_range(0, 1));
            z   = 1'($urandom_range(0, 1));
            n   = 1'($urandom_range(0, 1));
            go_to(s);
            flags(m, z, n);
            case (cs)
                2'd0: cv = m;
                2'd1: cv = z;
                2'd2: cv = n;
                default: cv = 1'b1;
            endcase
            cv = cv ^ iv;
            drive(NS_BR, iv, cs, tgt, 7'd0);
            exp_q.push_back(cv ? tgt : s + 7'd1);
            cycle();
            exp_s = exp_q.pop_front();
            checks++;
            if (bus.current_state !== exp_s) begin
                failures++;
                $display("FAIL br_rand[%0d]: s=%0d cs=%0d inv=%b state=%0d want %0d",
                         i, s, cs, iv, bus.current_state, exp_s);
            end
        end
    endtask

    task automatic test_wait();
        do_reset();
        go_to(7'd30);
        flags(1'b0, 1'b0, 1'b0);
        drive(NS_WAIT, 1'b0, 2'd0, 7'd0, 7'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) flags(1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if (bus.stall !== (i < 3)) begin
                failures++;
                $display("FAIL wait_stall[%0d]: stall=%b want %b", i, bus.stall, (i < 3));
            end
            exp_q.push_back(i < 3 ? 7'd30 : 7'd31);
            cycle();
            exp_s = exp_q.pop_front();
            checks++;
            if (bus.current_state !== exp_s) begin
                failures++;
                $display("FAIL wait_state[%0d]: state=%0d want %0d", i, bus.current_state, exp_s);
            end
        end
        // Condition arrives on the very cycle of the limit: advance, no timeout.
        go_to(7'd40);
        flags(1'b0, 1'b0, 1'b0);
        drive(NS_WAIT, 1'b0, 2'd0, 7'd0, 7'd0);
        for (int i = 0; i < 14; i++) cycle();
        flags(1'b1, 1'b0, 1'b0);
        exp_q.push_back(7'd41);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL wait_limit_race: state=%0d timeout=%b want %0d/0",
                     bus.current_state, bus.timeout, exp_s);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        go_to(7'd40);
        flags(1'b0, 1'b0, 1'b0);
        drive(NS_WAIT, 1'b0, 2'd0, 7'd0, 7'd0);
        for (int i = 1; i <= 15; i++) begin
            exp_q.push_back(i < 15 ? 7'd40 : 7'd0);
            cycle();
            exp_s = exp_q.pop_front();
            checks++;
            if (bus.current_state !== exp_s || bus.timeout !== (i == 15)) begin
                failures++;
                $display("FAIL timeout_edge[%0d]: state=%0d timeout=%b want %0d/%b",
                         i, bus.current_state, bus.timeout, exp_s, (i == 15));
            end
        end
        drive(NS_INC, 1'b0, 2'd0, 7'd0, 7'd0);
        cycle();
        cycle();
        checks++;
        if (bus.timeout !== 1'b1 || bus.illegal !== 1'b0 || bus.current_state !== 7'd2) begin
            failures++;
            $display("FAIL timeout_sticky: timeout=%b illegal=%b state=%0d want 1/0/2",
                     bus.timeout, bus.illegal, bus.current_state);
        end
        do_reset();
        checks++;
        if (bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: timeout=%b want 0", bus.timeout);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        go_to(7'd60);
        checks++;
        if (bus.current_state !== 7'd60 || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL ill_last_legal: state=%0d illegal=%b want 60/0", bus.current_state, bus.illegal);
        end
        drive(NS_INC, 1'b0, 2'd0, 7'd0, 7'd0);
        exp_q.push_back(7'd0);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b1) begin
            failures++;
            $display("FAIL ill_inc60: state=%0d illegal=%b want 0/1", bus.current_state, bus.illegal);
        end
        do_reset();
        drive(NS_ENC, 1'b0, 2'd0, 7'd0, 7'd127);
        exp_q.push_back(7'd0);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b1) begin
            failures++;
            $display("FAIL ill_enc127: state=%0d illegal=%b want 0/1", bus.current_state, bus.illegal);
        end
        do_reset();
        drive(NS_JUMP, 1'b0, 2'd0, 7'd61, 7'd0);
        exp_q.push_back(7'd0);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b1) begin
            failures++;
            $display("FAIL ill_jump61: state=%0d illegal=%b want 0/1", bus.current_state, bus.illegal);
        end
    endtask

    task automatic test_subroutine();
        do_reset();
`ifdef MICROSEQ_RETURN_EN
        go_to(7'd9);
        drive(NS_CALL, 1'b0, 2'd0, 7'd30, 7'd0);
        exp_q.push_back(7'd30);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL call: state=%0d illegal=%b want %0d/0", bus.current_state, bus.illegal, exp_s);
        end
        drive(NS_RET, 1'b0, 2'd0, 7'd0, 7'd0);
        exp_q.push_back(7'd10);
        exp_q.push_back(7'd0);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL ret: state=%0d illegal=%b want %0d/0", bus.current_state, bus.illegal, exp_s);
        end
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b1) begin
            failures++;
            $display("FAIL ret_empty: state=%0d illegal=%b want %0d/1", bus.current_state, bus.illegal, exp_s);
        end
        // Nested CALL overwrites the return address.
        do_reset();
        go_to(7'd2);
        drive(NS_CALL, 1'b0, 2'd0, 7'd10, 7'd0);
        cycle();
        drive(NS_CALL, 1'b0, 2'd0, 7'd20, 7'd0);
        cycle();
        drive(NS_RET, 1'b0, 2'd0, 7'd0, 7'd0);
        exp_q.push_back(7'd11);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL ret_nested: state=%0d illegal=%b want %0d/0", bus.current_state, bus.illegal, exp_s);
        end
`else
        go_to(7'd9);
        drive(NS_CALL, 1'b0, 2'd0, 7'd30, 7'd0);
        exp_q.push_back(7'd0);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b1) begin
            failures++;
            $display("FAIL call_off: state=%0d illegal=%b want %0d/1", bus.current_state, bus.illegal, exp_s);
        end
        do_reset();
        go_to(7'd9);
        drive(NS_RET, 1'b0, 2'd0, 7'd0, 7'd0);
        exp_q.push_back(7'd0);
        cycle();
        exp_s = exp_q.pop_front();
        checks++;
        if (bus.current_state !== exp_s || bus.illegal !== 1'b1) begin
            failures++;
            $display("FAIL ret_off: state=%0d illegal=%b want %0d/1", bus.current_state, bus.illegal, exp_s);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        flags(1'b0, 1'b0, 1'b0);
        drive(NS_FETCH, 1'b0, 2'd0, 7'd0, 7'd0);
        test_reset();
        test_sequence();
        test_branch();
        test_wait();
        test_timeout();
        test_illegal();
        test_subroutine();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
